// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state type and constants for the PWM duty meter
package pwm_pkg;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    localparam int PCT_SCALE = 100;
    localparam int PCT_W = 7;
    localparam int DIV_ITERS = 7;
endpackage

// File: rtl/pwm_pct_div.sv
// pwm_pct_div: sequential restoring divider giving floor(hi*100/per), one quotient bit per cycle
module pwm_pct_div
    import pwm_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     hi,
    input  logic [W-1:0]     per,
    output logic             busy,
    output logic             done,
    output logic [PCT_W-1:0] quo
);
    localparam int RW = W + PCT_W;
    localparam logic [RW-1:0] SCALE = RW'(PCT_SCALE);
    localparam logic [2:0] LAST = 3'(DIV_ITERS - 1);
    logic [RW-1:0] rem, rem_in, d_sh;
    logic [W-1:0] per_q, dv;
    logic [2:0] k, k_in;
    logic run, ge;
    // the start edge resolves the top quotient bit straight from the live operands
    assign rem_in = start ? {{PCT_W{1'b0}}, hi} * SCALE : rem;
    assign dv = start ? per : per_q;
    assign k_in = start ? 3'd0 : k;
    assign d_sh = {1'b0, dv, {(PCT_W-1){1'b0}}} >> k_in;
    assign ge = rem_in >= d_sh;
    assign busy = run | done;
    // one restoring step per cycle, quotient shifted in MSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            done <= 1'b0;
            k <= '0;
            rem <= '0;
            per_q <= '0;
            quo <= '0;
        end else begin
            done <= run && k == LAST;
            if (start || run) begin
                rem <= ge ? rem_in - d_sh : rem_in;
                quo <= start ? {{(PCT_W-1){1'b0}}, ge} : {quo[PCT_W-2:0], ge};
                k <= start ? 3'd1 : k + 3'd1;
                run <= start || k != LAST;
            end
            if (start) per_q <= per;
        end
    end
endmodule

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures period, high time and whole-percent duty of an asynchronous PWM input
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [PCT_W-1:0] duty_pct,
    output logic             meas_valid,
    output logic             overrun
);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0] cnt, hi, pend_per, pend_hi;
    logic [PCT_W-1:0] quo;
    logic s, s_d, rise, fall, tmo, start, div_busy, div_done;
    state_t state;
    assign s = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;
    assign tmo = cnt == TMO;
    // a closing rise either starts the divider or, if it is still busy, is discarded as an overrun
    assign start = state == LOW && rise && !div_busy;
    assign overrun = state == LOW && rise && div_busy;
    // input synchronizer and one-cycle delay for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            s_d <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_in};
            s_d <= s;
        end
    end
    // cycles since the last rise, saturating at the timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= rise ? CNT_W'(1) : tmo ? cnt : cnt + CNT_W'(1);
    end
    // measurement FSM: latches high time and period, publishes results and stuck-level reports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hi <= '0;
            pend_per <= '0;
            pend_hi <= '0;
            period <= '0;
            high_time <= '0;
            duty_pct <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= div_done;
            if (div_done) begin
                period <= pend_per;
                high_time <= pend_hi;
                duty_pct <= quo;
            end
            if (start) begin
                pend_per <= cnt;
                pend_hi <= hi;
            end
            case (state)
                IDLE: if (rise) state <= HIGH;
                HIGH: begin
                    if (fall) begin
                        hi <= cnt;
                        state <= LOW;
                    end else if (tmo) begin
                        period <= '0;
                        high_time <= '0;
                        duty_pct <= PCT_W'(PCT_SCALE);
                        meas_valid <= 1'b1;
                        state <= IDLE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                    end else if (tmo) begin
                        period <= '0;
                        high_time <= '0;
                        duty_pct <= '0;
                        meas_valid <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    pwm_pct_div #(.W(CNT_W)) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .hi   (hi),
        .per  (cnt),
        .busy (div_busy),
        .done (div_done),
        .quo  (quo)
    );
endmodule
